// File: rtl/encoder_job_scheduler.sv
// Round-robin scheduler that time-shares the encoder round core between requesters.
// Optional watchdog abort of a hung core is built when WATCHDOG_EN is defined.
module encoder_job_scheduler #(
  parameter int NREQ    = 2,
  parameter int NWORDS  = 25,
  parameter int AW      = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      ld_we,
  output logic [AW-1:0]             ld_addr,
  output logic                      core_start,
  input  logic                      core_ready,
  output logic                      rd_en,
  output logic [AW-1:0]             rd_addr,
  output logic                      rd_valid,
  output logic                      err
);

  localparam int OW = $clog2(NREQ);
  localparam logic [AW-1:0] LAST_WORD = AW'(NWORDS - 1);

  if ((2 ** AW) < NWORDS) begin : g_chk_aw
    $error("AW too narrow for NWORDS");
  end
  if (TIMEOUT < 2) begin : g_chk_timeout
    $error("TIMEOUT must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD, RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            rd_valid_q;
  logic [OW:0]     pick;

`ifdef WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0]   wdog_q, wdog_d;
`endif

  // First requester strictly after the last owner, scanning circularly.
  function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [OW-1:0]   last);
    logic [OW:0]   res;
    logic [OW-1:0] c;
    res = '0;
    c   = last;
    for (int i = 0; i < NREQ; i++) begin
      c = (c == OW'(NREQ - 1)) ? '0 : c + 1'b1;
      if (!res[OW] && r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  assign pick = rr_pick(req, last_q);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    gnt        = '0;
    done       = '0;
    ld_we      = 1'b0;
    ld_addr    = '0;
    core_start = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    err        = 1'b0;
`ifdef WATCHDOG_EN
    wdog_d     = wdog_q;
`endif
    if (state_q != IDLE) gnt[owner_q] = 1'b1;

    case (state_q)
      IDLE: begin
        if (pick[OW] && core_ready) begin
          owner_d = pick[OW-1:0];
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ld_we   = 1'b1;
        ld_addr = cnt_q;
        if (cnt_q == LAST_WORD) state_d = START;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      START: begin
        core_start = 1'b1;
        state_d    = WAIT_BUSY;
`ifdef WATCHDOG_EN
        wdog_d     = '0;
`endif
      end
      WAIT_BUSY: begin
        if (!core_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (core_ready) begin
          cnt_d   = '0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        rd_en   = 1'b1;
        rd_addr = cnt_q;
        if (cnt_q == LAST_WORD) state_d = RELEASE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      RELEASE: begin
        done[owner_q] = 1'b1;
        last_d        = owner_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef WATCHDOG_EN
    // A hung core is abandoned: the owner still gets done, flagged by err.
    if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
      wdog_d = wdog_q + 1'b1;
      if (wdog_q == WDOG_LAST) begin
        err           = 1'b1;
        done[owner_q] = 1'b1;
        last_d        = owner_q;
        state_d       = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= OW'(NREQ - 1);
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
`ifdef WATCHDOG_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_en;
`ifdef WATCHDOG_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign owner    = owner_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_encoder_job_scheduler.sv
// Scoreboard bench for encoder_job_scheduler with a simple busy-counter core model.
module tb_encoder_job_scheduler;
  localparam int NW = 25;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt, done;
  logic [0:0] owner;
  logic       ld_we, core_start, core_ready, rd_en, rd_valid, err;
  logic [4:0] ld_addr, rd_addr;

  encoder_job_scheduler #(.NREQ(2), .NWORDS(NW), .AW(5), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done(done), .owner(owner),
    .ld_we(ld_we), .ld_addr(ld_addr), .core_start(core_start),
    .core_ready(core_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Core model: goes busy for busy_len cycles after each start pulse.
  int busy_len = 10;
  bit force_low = 1'b0;
  int busy_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)             busy_cnt <= 0;
    else if (core_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign core_ready = !force_low && (busy_cnt == 0);

  typedef struct { logic [1:0] d; bit e; int lat; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic push(input logic [1:0] d, input bit e, input int lat);
    exp_t x;
    x.d = d; x.e = e; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event not seen within cycle budget", nm);
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (done == 2'b00 && n < maxc);
    if (done == 2'b00) timeout_fail("done_timeout");
  endtask

  task automatic wait_start(input int maxc);
    int n;
    n = 0;
    while (!core_start && n < maxc) begin @(negedge clk); n++; end
    if (!core_start) timeout_fail("start_timeout");
  endtask

  // Monitor: per-cycle relations plus per-job scoreboard at each done pulse.
  int  cyc = 0, ld_cnt = 0, rd_cnt = 0, cs_cnt = 0, rv_cnt = 0;
  int  first_ld = 0, last_done = -100;
  bit  prev_rd_en = 1'b0;
  bit  gap_chk = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      ld_cnt = 0; rd_cnt = 0; cs_cnt = 0; rv_cnt = 0; prev_rd_en = 1'b0;
    end else begin
      chk("gnt_onehot0", int'($onehot0(gnt)), 1);
      if (core_start) chk("start_overlap", int'(ld_we | rd_en), 0);
      chk("rd_valid_lag", int'(rd_valid), int'(prev_rd_en));
      prev_rd_en = rd_en;
      if (ld_we) begin
        if (ld_cnt == 0) begin
          first_ld = cyc;
          if (gap_chk) chk("idle_gap", cyc - last_done, 2);
        end
        chk("ld_addr", int'(ld_addr), ld_cnt);
        ld_cnt++;
      end
      if (rd_en) begin
        chk("rd_addr", int'(rd_addr), rd_cnt);
        rd_cnt++;
      end
      if (core_start) cs_cnt++;
      if (rd_valid) rv_cnt++;
      if (done != 2'b00) begin
        if (exp_q.size() == 0) chk("unexpected_done", int'(done), 0);
        else begin
          e = exp_q.pop_front();
          chk("done_vec", int'(done), int'(e.d));
          chk("err", int'(err), int'(e.e));
          chk("gnt_at_done", int'(gnt), int'(e.d));
          chk("owner", int'(owner), int'(e.d[1]));
          chk("ld_words", ld_cnt, NW);
          chk("starts", cs_cnt, 1);
          chk("rd_words", rd_cnt, e.e ? 0 : NW);
          chk("rd_valid_words", rv_cnt, e.e ? 0 : NW);
          if (e.lat >= 0) chk("latency", cyc - first_ld, e.lat);
        end
        last_done = cyc;
        ld_cnt = 0; rd_cnt = 0; cs_cnt = 0; rv_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int stuck;
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_ld_we", int'(ld_we), 0);
    chk("rst_core_start", int'(core_start), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_req_gnt", int'(gnt), 0);

    // Single job for requester 0, core busy 10 cycles.
    push(2'b01, 1'b0, 62);
    req = 2'b01;
    wait_done(200);
    req = 2'b00;

    // Fresh reset, then both requesting for four jobs.
    @(negedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(2'b01, 1'b0, 62); push(2'b10, 1'b0, 62);
    push(2'b01, 1'b0, 62); push(2'b10, 1'b0, 62);
    req = 2'b11;
    wait_done(200);
    gap_chk = 1'b1;
    wait_done(200);
    wait_done(200);
    wait_done(200);
    gap_chk = 1'b0;

    // Core not ready while requester 1 waits in IDLE.
    req = 2'b10;
    force_low = 1'b1;
    push(2'b10, 1'b0, -1);
    repeat (6) begin
      @(negedge clk);
      chk("no_gnt_core_busy", int'(gnt), 0);
    end
    force_low = 1'b0;
    @(negedge clk);
    chk("gnt_after_ready", int'(gnt), 2);
    wait_done(200);
    req = 2'b00;

    // Requester 0 drops req during word 5 of the load.
    push(2'b01, 1'b0, 62);
    req = 2'b01;
    n = 0;
    while (!(ld_we && ld_addr == 5'd5) && n < 50) begin @(negedge clk); n++; end
    if (!(ld_we && ld_addr == 5'd5)) timeout_fail("ld_word5_timeout");
    req = 2'b00;
    wait_done(200);

    // Reset while the core is busy aborts the job silently.
    busy_len = 40;
    req = 2'b10;
    wait_start(100);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_gnt", int'(gnt), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_owner", int'(owner), 0);
    chk("abort_ld_we", int'(ld_we), 0);
    chk("abort_rd_en", int'(rd_en), 0);
    chk("abort_core_start", int'(core_start), 0);
    chk("abort_rd_valid", int'(rd_valid), 0);
    chk("abort_err", int'(err), 0);
    busy_len = 10;
    repeat (2) @(negedge clk);
    push(2'b10, 1'b0, 62);
    rst = 1'b0;
    @(negedge clk);
    chk("gnt_after_abort", int'(gnt), 2);
    wait_done(200);
    req = 2'b00;

    // Core that never finishes.
    busy_len = 300;
`ifdef WATCHDOG_EN
    push(2'b01, 1'b1, 89);
    req = 2'b01;
    wait_done(300);
    req = 2'b00;
    @(negedge clk);
    chk("idle_after_wdog_gnt", int'(gnt), 0);
    chk("idle_after_wdog_err", int'(err), 0);
`else
    req = 2'b01;
    wait_start(100);
    req = 2'b00;
    stuck = 0;
    repeat (150) begin
      @(negedge clk);
      if (gnt == 2'b01 && done == 2'b00 && !rd_en && !ld_we && !err) stuck++;
    end
    chk("stuck_in_wait", stuck, 150);
    push(2'b01, 1'b0, -1);
    wait_done(400);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
